// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Round-robin arbitration on ties, fixed MEM_LATENCY busy cycles, one-cycle ready pulse.
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 32'd1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        last_data_r;
  logic        we_r;
  logic        mem_en_r;
  logic        mem_we_r;
  logic        if_ready_r;
  logic        d_ready_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [2:0]  funct3_r;
  logic [31:0] if_rdata_r;
  logic [31:0] d_rdata_r;

  logic        d_req_s;
  logic        grant_d_s;

  assign d_req_s   = d_rd | d_wr;
  // Data wins unless fetch is also waiting and data was served last.
  assign grant_d_s = d_req_s & ~(if_req & last_data_r);

  // Arbitration FSM with latched access parameters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      last_data_r <= 1'b0;
      we_r        <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      if_ready_r  <= 1'b0;
      d_ready_r   <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      funct3_r    <= 3'd0;
      if_rdata_r  <= 32'd0;
      d_rdata_r   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if_ready_r <= 1'b0;
          d_ready_r  <= 1'b0;
          if (grant_d_s) begin
            state_r     <= BUSY_D;
            cnt_r       <= CNT_LOAD;
            last_data_r <= 1'b1;
            addr_r      <= d_addr;
            wdata_r     <= d_wdata;
            funct3_r    <= d_funct3;
            we_r        <= d_wr;
            mem_en_r    <= 1'b1;
            mem_we_r    <= d_wr;
          end else if (if_req) begin
            state_r     <= BUSY_IF;
            cnt_r       <= CNT_LOAD;
            last_data_r <= 1'b0;
            addr_r      <= if_addr;
            funct3_r    <= 3'b010;
            we_r        <= 1'b0;
            mem_en_r    <= 1'b1;
            mem_we_r    <= 1'b0;
          end else begin
            state_r  <= IDLE;
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
          end
        end
        BUSY_IF: begin
          if (cnt_r == 4'd0) begin
            if_rdata_r <= mem_rdata;
            if_ready_r <= 1'b1;
            mem_en_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            state_r    <= DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        BUSY_D: begin
          if (cnt_r == 4'd0) begin
            if (!we_r) begin
              d_rdata_r <= mem_rdata;
            end
            d_ready_r <= 1'b1;
            mem_en_r  <= 1'b0;
            mem_we_r  <= 1'b0;
            state_r   <= DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE: begin
          if_ready_r <= 1'b0;
          d_ready_r  <= 1'b0;
          mem_en_r   <= 1'b0;
          mem_we_r   <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= 4'd0;
          if_ready_r <= 1'b0;
          d_ready_r  <= 1'b0;
          mem_en_r   <= 1'b0;
          mem_we_r   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = addr_r;
  assign mem_wdata  = wdata_r;
  assign mem_funct3 = funct3_r;
  assign if_rdata   = if_rdata_r;
  assign d_rdata    = d_rdata_r;
  assign if_ready   = if_ready_r;
  assign d_ready    = d_ready_r;
  assign stall      = (if_req & ~if_ready_r) | (d_req_s & ~d_ready_r);

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives a MEM_LATENCY=2 and a MEM_LATENCY=1 arbiter with identical stimulus and
// compares both against a transaction-timestamp reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_funct3;
  logic [31:0] mem_rdata;

  logic [1:0][31:0] if_rdata_w;
  logic [1:0][31:0] d_rdata_w;
  logic [1:0][31:0] mem_addr_w;
  logic [1:0][31:0] mem_wdata_w;
  logic [1:0][2:0]  mem_funct3_w;
  logic [1:0]       if_ready_w;
  logic [1:0]       d_ready_w;
  logic [1:0]       mem_en_w;
  logic [1:0]       mem_we_w;
  logic [1:0]       stall_w;

  mem_arbiter #(.MEM_LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_w[0]), .if_ready(if_ready_w[0]),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_rdata(d_rdata_w[0]), .d_ready(d_ready_w[0]),
    .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
    .mem_wdata(mem_wdata_w[0]), .mem_funct3(mem_funct3_w[0]), .mem_rdata(mem_rdata),
    .stall(stall_w[0])
  );

  mem_arbiter #(.MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_w[1]), .if_ready(if_ready_w[1]),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_rdata(d_rdata_w[1]), .d_ready(d_ready_w[1]),
    .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
    .mem_wdata(mem_wdata_w[1]), .mem_funct3(mem_funct3_w[1]), .mem_rdata(mem_rdata),
    .stall(stall_w[1])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_edge   = 0;

  // Reference model: each access is a record with a grant timestamp.
  int          lat [2] = '{2, 1};
  bit          has [2];
  int          t_start [2];
  bit          t_data [2];
  bit          t_we [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [2:0]  m_f3 [2];
  logic [31:0] m_if [2];
  logic [31:0] m_d [2];
  bit          last_data [2];
  int          next_grant [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic bit m_busy(input int i);
    return has[i] && (n_edge >= t_start[i]) && (n_edge < t_start[i] + lat[i]);
  endfunction

  function automatic bit m_done(input int i);
    return has[i] && (n_edge == t_start[i] + lat[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      has[i] = 1'b0; t_start[i] = 0; t_data[i] = 1'b0; t_we[i] = 1'b0;
      m_addr[i] = 32'd0; m_wdata[i] = 32'd0; m_f3[i] = 3'd0;
      m_if[i] = 32'd0; m_d[i] = 32'd0; last_data[i] = 1'b0; next_grant[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit take_d;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        if (has[i] && n_edge == t_start[i] + lat[i]) begin
          if (!t_data[i]) m_if[i] = mem_rdata;
          else if (!t_we[i]) m_d[i] = mem_rdata;
        end
        if (n_edge >= next_grant[i] && (if_req || d_rd || d_wr)) begin
          take_d = (d_rd || d_wr) && !(if_req && last_data[i]);
          has[i] = 1'b1; t_start[i] = n_edge; t_data[i] = take_d; last_data[i] = take_d;
          next_grant[i] = n_edge + lat[i] + 2;
          if (take_d) begin
            t_we[i] = d_wr; m_addr[i] = d_addr; m_wdata[i] = d_wdata; m_f3[i] = d_funct3;
          end else begin
            t_we[i] = 1'b0; m_addr[i] = if_addr; m_f3[i] = 3'b010;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("L%0d_mem_en", lat[i]), 32'(mem_en_w[i]), 32'(m_busy(i)));
      check_val($sformatf("L%0d_mem_we", lat[i]), 32'(mem_we_w[i]), 32'(m_busy(i) && t_data[i] && t_we[i]));
      check_val($sformatf("L%0d_if_ready", lat[i]), 32'(if_ready_w[i]), 32'(m_done(i) && !t_data[i]));
      check_val($sformatf("L%0d_d_ready", lat[i]), 32'(d_ready_w[i]), 32'(m_done(i) && t_data[i]));
      check_val($sformatf("L%0d_mem_addr", lat[i]), mem_addr_w[i], m_addr[i]);
      check_val($sformatf("L%0d_mem_funct3", lat[i]), 32'(mem_funct3_w[i]), 32'(m_f3[i]));
      check_val($sformatf("L%0d_if_rdata", lat[i]), if_rdata_w[i], m_if[i]);
      check_val($sformatf("L%0d_d_rdata", lat[i]), d_rdata_w[i], m_d[i]);
      if (m_busy(i) && t_data[i])
        check_val($sformatf("L%0d_mem_wdata", lat[i]), mem_wdata_w[i], m_wdata[i]);
    end
  endtask

  task automatic check_stall();
    bit exp;
    for (int i = 0; i < 2; i++) begin
      exp = (if_req && !(m_done(i) && !t_data[i])) ||
            ((d_rd || d_wr) && !(m_done(i) && t_data[i]));
      check_val($sformatf("L%0d_stall", lat[i]), 32'(stall_w[i]), 32'(exp));
    end
  endtask

  task automatic tick();
    #1;
    check_stall();
    @(posedge clk);
    n_edge++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_idle();
    if_req = 1'b0; if_addr = 32'd0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; d_funct3 = 3'd0; mem_rdata = 32'd0;
  endtask

  // Asserted away from the clock edge so the asynchronous clear is observed directly.
  task automatic apply_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    set_idle();
    apply_reset();

    // Fetch at 0x40; address changes and request drops while busy.
    if_req = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h0050_0093;
    tick();
    if_addr = 32'h0000_0080;
    tick();
    if_req = 1'b0;
    repeat (4) tick();

    // Store of 0xDEADBEEF at 0x100, byte width code.
    d_wr = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b000;
    mem_rdata = 32'h1234_5678;
    tick();
    d_wr = 1'b0;
    repeat (5) tick();

    // Load at 0x200.
    d_rd = 1'b1; d_addr = 32'h0000_0200; d_funct3 = 3'b010; mem_rdata = 32'hCAFE_0001;
    tick();
    d_rd = 1'b0;
    repeat (5) tick();

    // Held tie after reset: data, fetch, data ...
    set_idle();
    apply_reset();
    if_req = 1'b1; if_addr = 32'h0000_0300; d_rd = 1'b1; d_addr = 32'h0000_0400;
    mem_rdata = 32'h0BAD_F00D;
    repeat (14) tick();

    // Reset landing inside a data access, then a tie after release.
    set_idle();
    d_wr = 1'b1; d_addr = 32'h0000_0500; d_wdata = 32'h5555_AAAA; d_funct3 = 3'b001;
    tick();
    tick();
    apply_reset();
    if_req = 1'b1; d_rd = 1'b1; d_addr = 32'h0000_0600; if_addr = 32'h0000_0700;
    repeat (6) tick();

    for (int c = 0; c < 600; c++) begin
      if_req    = ($urandom_range(0, 2) != 0);
      d_rd      = ($urandom_range(0, 2) == 0);
      d_wr      = ($urandom_range(0, 3) == 0);
      if_addr   = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_funct3  = 3'($urandom_range(0, 7));
      mem_rdata = $urandom;
      if ($urandom_range(0, 79) == 0) apply_reset();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
